psum_spad_rmw: RTL and testbench

- Read-modify-write sequencer that sits directly upstream of the dual-port scratchpad holding partial sums in a PE.
- Accepts a valid/ready stream of (address, partial product) and issues the scratchpad read on port A.
- Adds the returned value and writes the sum back on port B.
- On the final accumulation for an address, also emits the result on a downstream valid/ready stream.
- Same-address back-to-back updates use internal forwarding, so throughput is one update per cycle.

---
 rtl/psum_spad_rmw.sv | 157 +++++++++++++++
 tb/tb_psum_spad_rmw.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_spad_rmw.sv
`default_nettype none
// ============================================================================
// Module   : psum_spad_rmw
// Purpose  : Read-modify-write sequencer for a dual-port partial-sum
//            scratchpad. Each accepted (addr, data) update reads the stored
//            word on port A. One cycle later it writes stored+data on port B.
//            An update marked last also presents its result on a
//            valid/ready output stream. Back-to-back updates to the same
//            address take the in-flight sum directly, so the block sustains
//            one update per cycle.
// Ports    : clk_i, rst_ni           clock, asynchronous active-low reset
//            in_*                    update request stream (valid/ready)
//            out_*                   final result stream (valid/ready)
//            spad_re_a_o/addr_r_a_o  scratchpad port A read request
//            spad_data_a_i           port A read data (one cycle after read)
//            spad_we_b_o/addr_w_b_o/data_b_o  scratchpad port B write
// Options  : PSUM_SAT_EN  when defined, the add saturates to the signed
//                         range of DATA_WIDTH instead of wrapping.
// Revision : 1.0  initial release
// ============================================================================
module psum_spad_rmw #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // update request stream
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_init_i,
    input  logic                  in_last_i,
    // result stream
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    // scratchpad port A (read)
    output logic                  spad_re_a_o,
    output logic [ADDR_WIDTH-1:0] spad_addr_r_a_o,
    input  logic [DATA_WIDTH-1:0] spad_data_a_i,
    // scratchpad port B (write)
    output logic                  spad_we_b_o,
    output logic [ADDR_WIDTH-1:0] spad_addr_w_b_o,
    output logic [DATA_WIDTH-1:0] spad_data_b_o
);

    // S1 pipeline state
    logic                  r_s1_valid;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_init;
    logic                  r_s1_last;
    logic                  r_s1_fwd;
    logic [DATA_WIDTH-1:0] r_s1_fwd_data;

    // Output register
    logic                  r_out_valid;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_accept;
    logic                  w_fwd_hit;
    logic [DATA_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_sum;

    // A last entry in S1 will load the output register at the end of this
    // cycle, so a new request is held off to keep that slot free.
    assign in_ready_o = (!r_out_valid || out_ready_i) && !(r_s1_valid && r_s1_last);
    assign w_accept   = in_valid_i && in_ready_o;

    assign spad_re_a_o     = w_accept;
    assign spad_addr_r_a_o = in_addr_i;

    // The write issued by S1 this cycle lands after the port A read of the
    // same cycle, so a same-address follower must take the sum directly.
    assign w_fwd_hit = r_s1_valid && (r_s1_addr == in_addr_i);

    // init wins over forwarding: the first update ignores any history.
    always_comb begin
        w_operand = spad_data_a_i;
        if (r_s1_init) begin
            w_operand = '0;
        end else if (r_s1_fwd) begin
            w_operand = r_s1_fwd_data;
        end
    end

`ifdef PSUM_SAT_EN
    localparam logic [DATA_WIDTH-1:0] c_sat_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_sat_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [DATA_WIDTH:0] w_sum_ext;
    logic                w_ovf;

    // One guard bit: overflow occurred when it disagrees with the result MSB,
    // and the guard bit then carries the true sign of the result.
    assign w_sum_ext = {w_operand[DATA_WIDTH-1], w_operand}
                     + {r_s1_data[DATA_WIDTH-1], r_s1_data};
    assign w_ovf     = w_sum_ext[DATA_WIDTH] ^ w_sum_ext[DATA_WIDTH-1];

    always_comb begin
        w_sum = w_sum_ext[DATA_WIDTH-1:0];
        if (w_ovf) begin
            w_sum = w_sum_ext[DATA_WIDTH] ? c_sat_min : c_sat_max;
        end
    end
`else
    assign w_sum = w_operand + r_s1_data;
`endif

    assign spad_we_b_o     = r_s1_valid;
    assign spad_addr_w_b_o = r_s1_addr;
    assign spad_data_b_o   = w_sum;

    assign out_valid_o = r_out_valid;
    assign out_addr_o  = r_out_addr;
    assign out_data_o  = r_out_data;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid    <= 1'b0;
            r_s1_addr     <= '0;
            r_s1_data     <= '0;
            r_s1_init     <= 1'b0;
            r_s1_last     <= 1'b0;
            r_s1_fwd      <= 1'b0;
            r_s1_fwd_data <= '0;
            r_out_valid   <= 1'b0;
            r_out_addr    <= '0;
            r_out_data    <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_addr     <= in_addr_i;
                r_s1_data     <= in_data_i;
                r_s1_init     <= in_init_i;
                r_s1_last     <= in_last_i;
                r_s1_fwd      <= w_fwd_hit;
                r_s1_fwd_data <= w_sum;
            end else begin
                r_s1_fwd      <= 1'b0;
            end

            if (r_s1_valid && r_s1_last) begin
                r_out_valid <= 1'b1;
                r_out_addr  <= r_s1_addr;
                r_out_data  <= w_sum;
            end else if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_spad_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_psum_spad_rmw
// Purpose  : Directed self-checking bench for psum_spad_rmw with a
//            behavioural dual-port scratchpad (registered port A read,
//            port B write, read-before-write on the same edge).
// Revision : 1.0  initial release
// ============================================================================
module tb_psum_spad_rmw;

    localparam int DW = 20;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, in_init, in_last;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          re, we;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] rdata, wdata;

    logic [DW-1:0] mem [1<<AW];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) rdata <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

    psum_spad_rmw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .in_valid_i      (in_valid),
        .in_ready_o      (in_ready),
        .in_addr_i       (in_addr),
        .in_data_i       (in_data),
        .in_init_i       (in_init),
        .in_last_i       (in_last),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_addr_o      (out_addr),
        .out_data_o      (out_data),
        .spad_re_a_o     (re),
        .spad_addr_r_a_o (raddr),
        .spad_data_a_i   (rdata),
        .spad_we_b_o     (we),
        .spad_addr_w_b_o (waddr),
        .spad_data_b_o   (wdata)
    );

    task automatic drive(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic init, input logic last);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_init  = init;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_init  = 1'b0;
        in_last  = 1'b0;
    endtask

    // Init-write a value, then leave one idle cycle so it settles in memory.
    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); drive(a, d, 1'b1, 1'b0);
        @(negedge clk); idle();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_addr !== '0 || out_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b ov=%b oa=%0d od=%0d, want 1 0 0 0",
                     in_ready, out_valid, out_addr, out_data);
        end
        tests++;
        if (we !== 1'b0) begin
            fails++;
            $display("FAIL reset_we: we=%b, want 0", we);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_init_last();
        @(negedge clk); drive(4'd3, 20'd5, 1'b1, 1'b0); #1;
        tests++;
        if (in_ready !== 1'b1 || re !== 1'b1 || raddr !== 4'd3 || we !== 1'b0) begin
            fails++;
            $display("FAIL il_accept: ready=%b re=%b raddr=%0d we=%b, want 1 1 3 0",
                     in_ready, re, raddr, we);
        end
        @(negedge clk); drive(4'd3, 20'd7, 1'b0, 1'b1); #1;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd3 || wdata !== 20'd5 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL il_write_init: we=%b waddr=%0d wdata=%0d ready=%b, want 1 3 5 1",
                     we, waddr, wdata, in_ready);
        end
        @(negedge clk); idle(); #1;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd3 || wdata !== 20'd12 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL il_write_fwd: we=%b waddr=%0d wdata=%0d ready=%b ov=%b, want 1 3 12 0 0",
                     we, waddr, wdata, in_ready, out_valid);
        end
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_addr !== 4'd3 || out_data !== 20'd12 || we !== 1'b0) begin
            fails++;
            $display("FAIL il_out: ov=%b oa=%0d od=%0d we=%b, want 1 3 12 0",
                     out_valid, out_addr, out_data, we);
        end
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL il_out_clear: ov=%b, want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        preload(4'd9, 20'd100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(4'd9, 20'd1, 1'b0, (i == 3)); #1;
            if (i == 0) begin
                tests++;
                if (we !== 1'b0 || in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_first: we=%b ready=%b, want 0 1", we, in_ready);
                end
            end else begin
                tests++;
                if (we !== 1'b1 || waddr !== 4'd9 || wdata !== DW'(100 + i) || in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_write%0d: we=%b waddr=%0d wdata=%0d ready=%b, want 1 9 %0d 1",
                             i, we, waddr, wdata, in_ready, 100 + i);
                end
            end
        end
        @(negedge clk); idle(); #1;
        tests++;
        if (we !== 1'b1 || wdata !== 20'd104 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_write4: we=%b wdata=%0d ready=%b, want 1 104 0", we, wdata, in_ready);
        end
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 1'b1 || out_addr !== 4'd9 || out_data !== 20'd104) begin
            fails++;
            $display("FAIL b2b_out: ov=%b oa=%0d od=%0d, want 1 9 104", out_valid, out_addr, out_data);
        end
    endtask

    task automatic test_interleave();
        logic [AW-1:0] a   [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
        logic [DW-1:0] d   [4] = '{20'd3, 20'd4, 20'd5, 20'd6};
        logic [DW-1:0] exp [4] = '{20'd13, 20'd24, 20'd18, 20'd30};
        @(negedge clk); drive(4'd1, 20'd10, 1'b1, 1'b0);
        @(negedge clk); drive(4'd2, 20'd20, 1'b1, 1'b0);
        @(negedge clk); idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(a[i], d[i], 1'b0, 1'b0); #1;
            if (i > 0) begin
                tests++;
                if (we !== 1'b1 || waddr !== a[i-1] || wdata !== exp[i-1]) begin
                    fails++;
                    $display("FAIL ilv_write%0d: we=%b waddr=%0d wdata=%0d, want 1 %0d %0d",
                             i - 1, we, waddr, wdata, a[i-1], exp[i-1]);
                end
            end
        end
        @(negedge clk); idle(); #1;
        tests++;
        if (we !== 1'b1 || waddr !== 4'd2 || wdata !== exp[3]) begin
            fails++;
            $display("FAIL ilv_write3: we=%b waddr=%0d wdata=%0d, want 1 2 30", we, waddr, wdata);
        end
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        @(negedge clk); drive(4'd5, 20'd42, 1'b1, 1'b1); #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL hold_accept: ready=%b, want 1", in_ready);
        end
        @(negedge clk); idle(); #1;
        tests++;
        if (we !== 1'b1 || wdata !== 20'd42 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL hold_write: we=%b wdata=%0d ready=%b, want 1 42 0", we, wdata, in_ready);
        end
        @(negedge clk); drive(4'd6, 20'd1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== 20'd42 || out_addr !== 4'd5 || in_ready !== 1'b0 || re !== 1'b0) begin
                fails++;
                $display("FAIL hold_cycle%0d: ov=%b od=%0d oa=%0d ready=%b re=%b, want 1 42 5 0 0",
                         i, out_valid, out_data, out_addr, in_ready, re);
            end
        end
        @(negedge clk); out_ready = 1'b1; #1;
        tests++;
        if (in_ready !== 1'b1 || re !== 1'b1 || raddr !== 4'd6) begin
            fails++;
            $display("FAIL hold_release: ready=%b re=%b raddr=%0d, want 1 1 6", in_ready, re, raddr);
        end
        @(negedge clk); idle(); #1;
        tests++;
        if (out_valid !== 1'b0 || we !== 1'b1 || waddr !== 4'd6 || wdata !== 20'd1) begin
            fails++;
            $display("FAIL hold_after: ov=%b we=%b waddr=%0d wdata=%0d, want 0 1 6 1",
                     out_valid, we, waddr, wdata);
        end
    endtask

    task automatic test_saturation();
`ifdef PSUM_SAT_EN
        logic [DW-1:0] exp_pos = 20'h7FFFF;
        logic [DW-1:0] exp_neg = 20'h80000;
`else
        logic [DW-1:0] exp_pos = 20'h80000;
        logic [DW-1:0] exp_neg = 20'h7FFFF;
`endif
        preload(4'd4, 20'h7FFFF);
        @(negedge clk); drive(4'd4, 20'd1, 1'b0, 1'b0);
        @(negedge clk); idle(); #1;
        tests++;
        if (we !== 1'b1 || wdata !== exp_pos) begin
            fails++;
            $display("FAIL sat_pos: we=%b wdata=%h, want 1 %h", we, wdata, exp_pos);
        end
        preload(4'd7, 20'h80000);
        @(negedge clk); drive(4'd7, 20'hFFFFF, 1'b0, 1'b0);
        @(negedge clk); idle(); #1;
        tests++;
        if (we !== 1'b1 || wdata !== exp_neg) begin
            fails++;
            $display("FAIL sat_neg: we=%b wdata=%h, want 1 %h", we, wdata, exp_neg);
        end
    endtask

    task automatic test_reset_kill();
        preload(4'd11, 20'd50);
        @(negedge clk); drive(4'd11, 20'd9, 1'b0, 1'b1); #1;
        tests++;
        if (re !== 1'b1) begin
            fails++;
            $display("FAIL kill_accept: re=%b, want 1", re);
        end
        @(negedge clk); idle(); rst_n = 1'b0; #1;
        tests++;
        if (we !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL kill_in_reset: we=%b ov=%b ready=%b, want 0 0 1", we, out_valid, in_ready);
        end
        @(negedge clk); rst_n = 1'b1; #1;
        tests++;
        if (we !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL kill_release: we=%b ov=%b, want 0 0", we, out_valid);
        end
        @(negedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || mem[11] !== 20'd50) begin
            fails++;
            $display("FAIL kill_mem: ov=%b mem11=%0d, want 0 50", out_valid, mem[11]);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_init   = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_init_last();
        test_back_to_back();
        test_interleave();
        test_hold();
        test_saturation();
        test_reset_kill();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
